// File: rtl/div3_sched.sv
// Round-robin front end sharing one bit-serial divide-by-3 engine between two
// requesters; results leave on a valid/ready channel with backpressure.
module div3_sched #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_x,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_x,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_q,
    output logic [1:0]       res_r,
    output logic             res_id,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // One MSB-first remainder step: returns {quotient_bit, next_remainder}.
    function automatic logic [2:0] div_step(input logic [1:0] r, input logic b);
        logic [2:0] t;
        t = {r, b};
        if (t >= 3'd3) begin
            div_step = {1'b1, 2'(t - 3'd3)};
        end else begin
            div_step = {1'b0, t[1:0]};
        end
    endfunction

    state_t           state_r;
    logic             last_r;
    logic [WIDTH-1:0] sh_r;
    logic [CW-1:0]    cnt_r;
    logic             grant0_s;
    logic             grant1_s;
    logic [2:0]       step_s;

    // Arbitration: last_r names the requester served last; the other one wins a tie.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (state_r == IDLE) begin
            grant0_s = req0_valid & (~req1_valid | last_r);
            grant1_s = req1_valid & (~req0_valid | ~last_r);
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
        step_s = div_step(res_r, sh_r[WIDTH-1]);
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;

    // Scheduler FSM, serial divider datapath and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            last_r    <= 1'b1;
            sh_r      <= '0;
            cnt_r     <= '0;
            res_valid <= 1'b0;
            res_q     <= '0;
            res_r     <= 2'b00;
            res_id    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant0_s | grant1_s) begin
                        sh_r    <= grant0_s ? req0_x : req1_x;
                        res_r   <= 2'b00;
                        cnt_r   <= CW'(WIDTH - 1);
                        res_id  <= grant1_s;
                        last_r  <= grant1_s;
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    // res_r doubles as the running remainder while the result is not yet valid.
                    sh_r  <= {sh_r[WIDTH-2:0], 1'b0};
                    res_q <= {res_q[WIDTH-2:0], step_s[2]};
                    res_r <= step_s[1:0];
                    cnt_r <= cnt_r - CW'(1);
                    if (cnt_r == '0) begin
                        state_r   <= DONE;
                        res_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_r   <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
